// File: rtl/rs_shared_alu_pkg.sv
// Shared constants for the round-robin shared add/sub unit.
// Also read by RS_SAT_EN builds; no content changes with that macro.
package rs_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Low bit of channel ch inside a packed per-channel bus.
  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rs_shared_alu_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, gated by en.
module rs_rr_arbiter #(
  parameter  int unsigned NCH  = 4,
  localparam int unsigned CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic hit_s;

  // Channel visited i steps after ptr, wrapping at NCH (NCH need not be a power of two).
  function automatic int unsigned rot(input logic [CH_W-1:0] p, input int unsigned i);
    int unsigned s;
    s = 32'(p) + i;
    return (s >= NCH) ? s - NCH : s;
  endfunction

  // Priority scan starting at ptr; only the first hit is granted.
  always_comb begin
    gnt     = {NCH{1'b0}};
    gnt_idx = {CH_W{1'b0}};
    any     = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      hit_s               = en & ~any & req[rot(ptr, i)];
      gnt[rot(ptr, i)]    = gnt[rot(ptr, i)] | hit_s;
      gnt_idx             = hit_s ? CH_W'(rot(ptr, i)) : gnt_idx;
      any                 = any | hit_s;
    end
  end

endmodule

// File: rtl/rs_shared_alu.sv
// NCH channels share one WIDTH-bit adder/subtractor behind a round-robin arbiter.
// Define RS_SAT_EN for saturating results (out_carry still reports raw carry/borrow).
module rs_shared_alu
  import rs_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NCH   = DEF_NCH,
  localparam int unsigned CH_W  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req_valid,
  output logic [NCH-1:0]     req_ready,
  input  logic [NCH-1:0]     req_op,
  input  logic [NCH*WIDTH-1:0] req_a,
  input  logic [NCH*WIDTH-1:0] req_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [WIDTH-1:0]   out_res,
  output logic               out_carry
);

  logic [CH_W-1:0]  ptr_r;
  logic [CH_W-1:0]  ptr_nxt_s;
  logic [CH_W-1:0]  gnt_idx_s;
  logic [NCH-1:0]   gnt_s;
  logic             any_s;
  logic             accept_s;
  logic             en_s;
  logic             op_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic [WIDTH-1:0] res_s;

  logic             out_valid_r;
  logic [CH_W-1:0]  out_ch_r;
  logic [WIDTH-1:0] out_res_r;
  logic             out_carry_r;

  // rst gating keeps req_ready low while the output register is held in reset.
  assign accept_s  = ~out_valid_r | out_ready;
  assign en_s      = accept_s & ~rst;
  assign req_ready = gnt_s;

  rs_rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .en      (en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any     (any_s)
  );

  // Operand mux feeding the single shared adder; subtract is a + ~b + 1.
  always_comb begin
    op_s    = req_op[gnt_idx_s];
    a_s     = req_a[ch_lo(32'(gnt_idx_s), WIDTH) +: WIDTH];
    b_s     = req_b[ch_lo(32'(gnt_idx_s), WIDTH) +: WIDTH];
    b_eff_s = (op_s == OP_SUB) ? ~b_s : b_s;
    sum_s   = {1'b0, a_s} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, op_s};
    carry_s = (op_s == OP_SUB) ? ~sum_s[WIDTH] : sum_s[WIDTH];
  end

`ifdef RS_SAT_EN
  // Clamp on overflow (add) or borrow (sub).
  always_comb begin
    if (carry_s) begin
      res_s = (op_s == OP_SUB) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      res_s = sum_s[WIDTH-1:0];
    end
  end
`else
  assign res_s = sum_s[WIDTH-1:0];
`endif

  assign ptr_nxt_s = (gnt_idx_s == CH_W'(NCH - 1)) ? {CH_W{1'b0}} : gnt_idx_s + CH_W'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= {CH_W{1'b0}};
      out_res_r   <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
      ptr_r       <= {CH_W{1'b0}};
    end else if (any_s) begin
      out_valid_r <= 1'b1;
      out_ch_r    <= gnt_idx_s;
      out_res_r   <= res_s;
      out_carry_r <= carry_s;
      ptr_r       <= ptr_nxt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_res   = out_res_r;
  assign out_carry = out_carry_r;

endmodule

// File: tb/tb_rs_shared_alu.sv
// Directed table-driven bench for rs_shared_alu (WIDTH=8, NCH=4); honours RS_SAT_EN.
module tb_rs_shared_alu;
  import rs_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [1:0]     out_ch;
  logic [W-1:0]   out_res;
  logic           out_carry;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rs_shared_alu #(.WIDTH(W), .NCH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_res   (out_res),
    .out_carry (out_carry)
  );

  typedef struct {
    int         ch;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wrap;
    logic       carry;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] rr_exp[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_op[k]       = op;
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  function automatic logic [7:0] exp_res(input logic op, input logic c, input logic [7:0] wrap);
`ifdef RS_SAT_EN
    if (c) return (op == OP_SUB) ? 8'h00 : 8'hFF;
`endif
    return wrap;
  endfunction

  initial begin
    tbl[0] = '{2, OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0};
    tbl[1] = '{0, OP_ADD, 8'hFF, 8'h02, 8'h01, 1'b1};
    tbl[2] = '{0, OP_SUB, 8'h01, 8'h03, 8'hFE, 1'b1};
    tbl[3] = '{1, OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[4] = '{3, OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0};
    tbl[5] = '{1, OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0};
    tbl[6] = '{3, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[7] = '{2, OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1};
    rr_exp[0] = 8'h01;
    rr_exp[1] = 8'h12;
    rr_exp[2] = 8'h23;
    rr_exp[3] = 8'h34;

    // Reset held for 3 cycles with requests pending: nothing may be accepted.
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_res", out_res, 8'h00);
      chk("rst_ready", req_ready, 4'b0000);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
    chk("idle_ready", req_ready, 4'b0000);

    // Single-channel vectors.
    for (int v = 0; v < 8; v++) begin
      set_ch(tbl[v].ch, tbl[v].op, tbl[v].a, tbl[v].b);
      req_valid = 4'b0001 << tbl[v].ch;
      #1;
      chk("vec_ready", req_ready, 4'b0001 << tbl[v].ch);
      step();
      req_valid = 4'b0000;
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_ch", out_ch, tbl[v].ch);
      chk("vec_res", out_res, exp_res(tbl[v].op, tbl[v].carry, tbl[v].wrap));
      chk("vec_carry", out_carry, tbl[v].carry);
      step();
      chk("vec_drain", out_valid, 1'b0);
    end

    // Round-robin from ptr=0 with all channels requesting, no bubbles.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_ch(k, OP_ADD, 8'(8'h10 * k + 1), 8'(k));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_ready", req_ready, 4'b0001 << (g % N));
      step();
      chk("rr_valid", out_valid, 1'b1);
      chk("rr_ch", out_ch, g % N);
      chk("rr_res", out_res, rr_exp[g % N]);
    end

    // Backpressure holding the ch0 result while ch1 and ch3 wait.
    req_valid = 4'b1010;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ch", out_ch, 2'd0);
      chk("bp_res", out_res, 8'h01);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_next", req_ready, 4'b0010);
    step();
    chk("bp_out_ch", out_ch, 2'd1);
    chk("bp_out_res", out_res, 8'h12);

    // Asynchronous reset during a stall (ptr is 2 at this point).
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    chk("mid_rst_res", out_res, 8'h00);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_ready", req_ready, 4'b0010);
    out_ready = 1'b1;
    step();
    chk("post_rst_ch", out_ch, 2'd1);
    chk("post_rst_ovalid", out_valid, 1'b1);
    req_valid = 4'b0000;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
